// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared types and helpers for the round-robin delay-unit scheduler
package counter_sched_pkg;
  localparam int cycles_width_lp = 16;
  localparam int width_lp = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_e;
  typedef struct packed {
    logic [cycles_width_lp-1:0] cycles;
    logic [width_lp-1:0]        data;
  } sched_req_s;
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/rr_arb_ptr.sv
// rr_arb_ptr: combinational round-robin pick starting at ptr_i, ascending with wrap
module rr_arb_ptr #(
  parameter int num_req_p = 4,
  localparam int lg_num_req_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]     req_i,
  input  logic [lg_num_req_lp-1:0] ptr_i,
  output logic [num_req_p-1:0]     grant_o,
  output logic [lg_num_req_lp-1:0] id_o,
  output logic                     v_o
);
  localparam int sw_lp = lg_num_req_lp + 1;
  logic [sw_lp-1:0] sum;
  // Scan from the farthest offset down so the closest valid requester to ptr_i wins last.
  always_comb begin
    id_o = '0;
    sum = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + sw_lp'(k);
      if (sum >= sw_lp'(num_req_p)) sum = sum - sw_lp'(num_req_p);
      if (req_i[sum[lg_num_req_lp-1:0]]) id_o = sum[lg_num_req_lp-1:0];
    end
  end
  assign v_o = |req_i;
  assign grant_o = v_o ? (num_req_p'(1) << id_o) : '0;
endmodule

// File: rtl/counter_rr_sched.sv
// counter_rr_sched: shares one timed-delay unit among num_req_p requesters, one transaction at a time
module counter_rr_sched
  import counter_sched_pkg::*;
#(
  parameter int num_req_p = 4,
  parameter int cycles_width_p = cycles_width_lp,
  parameter int width_p = width_lp,
  localparam int lg_num_req_lp = $clog2(num_req_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*cycles_width_p-1:0] req_cycles_i,
  input  logic [num_req_p*width_p-1:0]        req_data_i,
  output logic [num_req_p-1:0]                req_yumi_o,
  output logic [num_req_p-1:0]                resp_v_o,
  output logic [width_p-1:0]                  resp_data_o,
  input  logic [num_req_p-1:0]                resp_ready_i,
  output logic                                res_v_o,
  output logic [cycles_width_p-1:0]           res_cycles_o,
  output logic [width_p-1:0]                  res_data_o,
  input  logic                                res_yumi_i,
  input  logic                                res_v_i,
  input  logic [width_p-1:0]                  res_data_i,
  output logic                                res_ready_o
);
  sched_state_e state_q, state_d;
  logic [lg_num_req_lp-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, arb_id;
  logic [width_p-1:0] buf_q, buf_d;
  logic [num_req_p-1:0] arb_grant, grant_oh;
  logic arb_v;
  logic [num_req_p-1:0][cycles_width_p-1:0] cyc_arr;
  logic [num_req_p-1:0][width_p-1:0] data_arr;
  logic [cycles_width_p-1:0] sel_cycles;
  assign cyc_arr = req_cycles_i;
  assign data_arr = req_data_i;
  rr_arb_ptr #(.num_req_p(num_req_p)) u_arb (
    .req_i  (req_v_i),
    .ptr_i  (rr_ptr_q),
    .grant_o(arb_grant),
    .id_o   (arb_id),
    .v_o    (arb_v)
  );
  assign grant_oh = num_req_p'(1) << grant_id_q;
  assign sel_cycles = cyc_arr[grant_id_q];
  // The delay unit needs at least one cycle, so a zero count is promoted.
  assign res_cycles_o = (|sel_cycles) ? sel_cycles : cycles_width_p'(1);
  assign res_data_o = data_arr[grant_id_q];
  assign res_v_o = state_q == ISSUE;
  assign res_ready_o = state_q == WAIT;
  assign req_yumi_o = (state_q == ISSUE && res_yumi_i && !reset_i) ? grant_oh : '0;
  assign resp_v_o = (state_q == RESP) ? grant_oh : '0;
  assign resp_data_o = buf_q;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    buf_d = buf_q;
    unique case (state_q)
      IDLE: if (arb_v) begin
        grant_id_d = arb_id;
        state_d = ISSUE;
      end
      ISSUE: if (res_yumi_i) state_d = WAIT;
      WAIT: if (res_v_i) begin
        buf_d = res_data_i;
        state_d = RESP;
      end
      RESP: if (resp_ready_i[grant_id_q]) begin
        rr_ptr_d = lg_num_req_lp'(wrap_inc(int'(grant_id_q), num_req_p));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      buf_q <= buf_d;
    end
  end
  for (genvar i = 0; i < num_req_p; i++) begin : g_hold
    a_req_hold: assert property (@(posedge clk_i) disable iff (reset_i)
      req_v_i[i] && !req_yumi_o[i] |=> req_v_i[i] && $stable(cyc_arr[i]) && $stable(data_arr[i]));
  end
  a_res_v_wait: assert property (@(posedge clk_i) disable iff (reset_i) res_v_i |-> state_q == WAIT);
  a_arb_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(arb_grant) && (arb_v == |arb_grant));
endmodule

// File: tb/tb_counter_rr_sched.sv
// tb_counter_rr_sched: scoreboard bench with a bench-side delay unit and round-robin reference
module tb_counter_rr_sched;
  localparam int N = 4;
  localparam int CW = 16;
  localparam int DW = 32;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic [N-1:0] req_v_i = '0;
  logic [N*CW-1:0] req_cycles_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0] req_yumi_o, resp_v_o;
  logic [DW-1:0] resp_data_o;
  logic [N-1:0] resp_ready_i = '1;
  logic res_v_o, res_ready_o;
  logic [CW-1:0] res_cycles_o;
  logic [DW-1:0] res_data_o;
  logic res_yumi_i = 1'b0;
  logic res_v_i = 1'b0;
  logic [DW-1:0] res_data_i = '0;

  counter_rr_sched #(.num_req_p(N), .cycles_width_p(CW), .width_p(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_cycles_i(req_cycles_i), .req_data_i(req_data_i),
    .req_yumi_o(req_yumi_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .resp_ready_i(resp_ready_i), .res_v_o(res_v_o), .res_cycles_o(res_cycles_o),
    .res_data_o(res_data_o), .res_yumi_i(res_yumi_i), .res_v_i(res_v_i),
    .res_data_i(res_data_i), .res_ready_o(res_ready_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  logic stage_rst = 1'b1;
  logic [N-1:0] stage_v = '0;
  logic [N-1:0] clr = '0;
  logic [CW-1:0] stage_cyc [N];
  logic [DW-1:0] stage_dat [N];
  int rdy_hold [N];
  int stall = 0;
  int du_st = 0;
  int du_cnt = 0;
  logic [DW-1:0] du_data = '0;
  int ph = 0;
  int ptr = 0;
  int gid = 0;
  logic rst_chk = 1'b0;
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic post(input int i, input int cyc, input logic [DW-1:0] dat);
    stage_v[i] = 1'b1;
    stage_cyc[i] = CW'(cyc);
    stage_dat[i] = dat;
  endtask

  task automatic tick();
    logic [N-1:0] oh;
    int c;
    @(negedge clk_i);
    reset_i = stage_rst;
    for (int i = 0; i < N; i++) begin
      if (clr[i]) begin req_v_i[i] = 1'b0; clr[i] = 1'b0; end
      if (stage_v[i] && !req_v_i[i]) begin
        req_v_i[i] = 1'b1;
        req_cycles_i[i*CW +: CW] = stage_cyc[i];
        req_data_i[i*DW +: DW] = stage_dat[i];
        stage_v[i] = 1'b0;
      end
      resp_ready_i[i] = (rdy_hold[i] == 0);
    end
    res_yumi_i = !reset_i && res_v_o && du_st == 0 && stall == 0;
    if (!reset_i && res_v_o && du_st == 0 && stall > 0) stall--;
    res_v_i = !reset_i && du_st == 2;
    res_data_i = du_data;
    #1;
    if (rst_chk) begin
      chk("rst_req_yumi", req_yumi_o, 0);
      chk("rst_resp_v", resp_v_o, 0);
      chk("rst_res_v", res_v_o, 0);
      chk("rst_res_ready", res_ready_o, 0);
      rst_chk = 1'b0;
    end
    if (reset_i) begin
      ph = 0; ptr = 0; du_st = 0; rst_chk = 1'b1;
      sb.delete();
      return;
    end
    oh = N'(1) << gid;
    case (ph)
      0: begin
        chk("idle_res_v", res_v_o, 0);
        chk("idle_resp_v", resp_v_o, 0);
        if (|req_v_i) begin gid = rr_pick(req_v_i, ptr); ph = 1; end
      end
      1: begin
        c = int'(req_cycles_i[gid*CW +: CW]);
        chk("issue_v", res_v_o, 1);
        chk("issue_cycles", res_cycles_o, (c == 0) ? 1 : c);
        chk("issue_data", res_data_o, req_data_i[gid*DW +: DW]);
        chk("issue_yumi", req_yumi_o, res_yumi_i ? oh : '0);
        if (res_yumi_i) begin
          sb.push_back(req_data_i[gid*DW +: DW]);
          clr[gid] = 1'b1;
          ph = 2;
        end
      end
      2: begin
        chk("wait_ready", res_ready_o, 1);
        chk("wait_resp_v", resp_v_o, 0);
        if (res_v_i) ph = 3;
      end
      default: begin
        chk("resp_v", resp_v_o, oh);
        chk("resp_res_v", res_v_o, 0);
        if (sb.size() > 0) chk("resp_data", resp_data_o, sb[0]);
        else chk("resp_sb_nonempty", sb.size(), 1);
        if (resp_ready_i[gid]) begin
          if (sb.size() > 0) void'(sb.pop_front());
          ptr = (gid + 1) % N;
          ph = 0;
        end
      end
    endcase
    for (int i = 0; i < N; i++) if (resp_v_o[i] && rdy_hold[i] > 0) rdy_hold[i]--;
    if (du_st == 0 && res_yumi_i) begin
      du_cnt = int'(res_cycles_o);
      du_data = res_data_o;
      du_st = 1;
    end else if (du_st == 1) begin
      du_cnt--;
      if (du_cnt == 0) du_st = 2;
    end else if (du_st == 2 && res_ready_o) du_st = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    logic ok = 1'b0;
    while (n < 2000 && !ok) begin
      tick();
      n++;
      ok = ph == 0 && sb.size() == 0 && req_v_i == '0 && stage_v == '0 && clr == '0;
    end
    chk("drain_done", ok, 1);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (n < 500 && ph != p) begin tick(); n++; end
    chk("reach_phase", ph, p);
  endtask

  task automatic do_reset();
    stage_rst = 1'b1;
    tick();
    stage_rst = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin rdy_hold[i] = 0; stage_cyc[i] = '0; stage_dat[i] = '0; end
    do_reset();
    post(2, 5, 32'hA5);
    wait_done();
    post(0, 3, 32'h1000_0000);
    post(3, 2, 32'h3333_3333);
    wait_done();
    do_reset();
    for (int i = 0; i < N; i++) post(i, i + 1, 32'hC0DE_0000 + DW'(i));
    wait_done();
    post(0, 2, 32'h0A0A_0A0A);
    post(2, 1, 32'h2B2B_2B2B);
    wait_done();
    rdy_hold[1] = 10;
    post(1, 4, 32'hBEEF_0001);
    post(2, 3, 32'hBEEF_0002);
    wait_done();
    stall = 3;
    post(0, 2, 32'h5A5A_0000);
    wait_done();
    post(1, 0, 32'hFACE_0001);
    wait_done();
    post(3, 20, 32'h3030_3030);
    wait_phase(2);
    repeat (3) tick();
    stage_rst = 1'b1;
    post(0, 1, 32'h0000_0F0F);
    post(2, 1, 32'h0000_2F2F);
    tick();
    stage_rst = 1'b0;
    wait_done();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/counter_rr_sched.md
Name: counter_rr_sched

Overview:
- Round-robin scheduler that shares one timed-delay unit among num_req_p requesters.
- The delay unit accepts {cycles, data} on a valid/yumi interface, holds the data for the given number of cycles, then returns it on a valid/ready interface.
- This block arbitrates requests, issues one at a time to the unit, captures the unit's result, and routes it back to the granted requester.
- Sits between compute-model request sources and a single shared latency-modelling resource.

Parameters:
- num_req_p, 4, number of requesters (>=2)
- cycles_width_p, 16, width of the delay count
- width_p, 32, payload width
- lg_num_req_lp, $clog2(num_req_p), localparam, grant id width

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous, active-high reset
- req_v_i  input  num_req_p  per-requester request valid
- req_cycles_i  input  num_req_p*cycles_width_p  per-requester delay count
- req_data_i  input  num_req_p*width_p  per-requester payload
- req_yumi_o  output  num_req_p  one-hot request consumed
- resp_v_o  output  num_req_p  one-hot response valid
- resp_data_o  output  width_p  response payload, shared by all requesters
- resp_ready_i  input  num_req_p  per-requester response ready
- res_v_o  output  1  issue valid to delay unit
- res_cycles_o  output  cycles_width_p  issued delay count
- res_data_o  output  width_p  issued payload
- res_yumi_i  input  1  delay unit consumed issue
- res_v_i  input  1  delay unit result valid
- res_data_i  input  width_p  delay unit result payload
- res_ready_o  output  1  scheduler ready for result

Behaviour:
- The clock is clk_i. reset_i is synchronous and active-high. The delay unit shares the same reset.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0.
  - All outputs are 0: req_yumi_o, resp_v_o, res_v_o, res_ready_o. resp_data_o holds the buffer contents and is don't-care while resp_v_o=0.
- Requester protocol: valid/yumi. Once req_v_i[i]=1, req_cycles_i and req_data_i stay stable until req_yumi_o[i]. Dropping valid early is a protocol violation and is checked by assertion.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_v_i bit is set, pick the winner by round-robin. The scan starts at rr_ptr, ascends, and wraps.
  - Register grant_id and go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - res_v_o=1.
  - res_cycles_o = req_cycles_i[grant_id], except that 0 is forwarded as 1 (the unit requires a minimum of one cycle).
  - res_data_o = req_data_i[grant_id].
  - req_yumi_o[grant_id] = res_yumi_i, combinationally, in the same cycle.
  - On res_yumi_i, go to WAIT.
- WAIT:
  - res_ready_o=1 (registered-state decode only; no combinational path from res_v_i).
  - On res_v_i, capture res_data_i into the response buffer and go to RESP.
- RESP:
  - resp_v_o[grant_id]=1 and resp_data_o=buffer.
  - On resp_ready_i[grant_id]: rr_ptr <= (grant_id+1) mod num_req_p, then go to IDLE.
  - resp_ready_i of non-granted requesters is ignored.
- Exactly one request is outstanding at any time.
- Minimum latency, issue to response-valid: the cycle after res_v_i&res_ready_o.
- Minimum overhead per transaction: 1 arbitration cycle + 1 issue cycle + 1 response cycle.
- A new request arriving while busy waits. Its valid remains asserted and it competes at the next IDLE.
- rr_ptr wrap: from num_req_p-1 it advances to 0. If only one requester is active, it is granted back-to-back.
- Reset mid-operation returns to IDLE, discards any held response, and clears rr_ptr. No yumi is generated for an interrupted ISSUE.
- res_v_i outside WAIT is ignored (res_ready_o=0) and flagged by assertion.
- Cycles values wider than the count are not possible; no truncation occurs.

Decomposition:
- Shared package counter_sched_pkg:
  - state enum sched_state_e {IDLE, ISSUE, WAIT, RESP}
  - request struct {cycles, data}, parameterised via localparams
- One sub-module: rr_arb_ptr. Combinational round-robin pick from req vector and rr_ptr; outputs grant one-hot, grant id, and any-valid.
- Pointer and FSM registers stay in the top.

Test Plan:
- Single requester 2 sends cycles=5, data=0xA5: yumi[2] in ISSUE; resp_v_o=4'b0100 with data 0xA5 after unit latency; rr_ptr becomes 3.
- All four valid simultaneously from reset: grants in order 0,1,2,3, then back to 0. Each response is routed only to its own bit.
- Requester 1 sends cycles=0: res_cycles_o=1 and a response returns with the payload intact (no counter underflow).
- Response backpressure: resp_ready_i[1] held low for 10 cycles in RESP: resp_v_o[1] stays high with stable data, no new issue occurs, and the FSM leaves RESP only on ready.
- Delay unit slow accept: res_yumi_i low for 3 cycles in ISSUE: res_v_o and res_cycles_o/res_data_o are held stable and req_yumi_o stays 0 until yumi.
- Reset asserted in WAIT with requester 3 outstanding: next cycle state=IDLE, all outputs 0, rr_ptr=0; the later result is ignored and requester 0 is granted first after reset.
